bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Clocked, parametrised successor to the countdown clock's BCD minutes:seconds counter.
- Counts NUM_GROUPS base-60 groups of two BCD digits each, e.g. MM:SS or HH:MM:SS, up or down, one step per tick pulse.
- Adds synchronous reset, parallel load with BCD clamping, a wrap/saturate mode, and terminal-count flags.
- Feeds the seven-segment display mux and the doomsday alarm logic.

Parameters:
- NUM_GROUPS, 2, number of base-60 digit pairs; total width W = 8*NUM_GROUPS (legal range 1..4).
- WRAP, 1, 1 = wrap at the ends of the range; 0 = saturate at the end and hold.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- tick  input  1  count-enable pulse; one step per cycle in which it is high.
- mode  input  1  1 = count down, 0 = count up; sampled on every tick.
- load  input  1  synchronous parallel load strobe.
- load_val  input  W  BCD value to load; digit order matches Y.
- Y  output  W  current count; digit 0 (seconds units) in Y[3:0], digit 2k+1 is a tens digit.
- at_zero  output  1  high while Y is all zeros.
- at_max  output  1  high while every group equals 5,9.
- term  output  1  one-cycle pulse, see Behaviour.

Behaviour:
- Digit limits: even-index digits 0..9, odd-index digits 0..5. Y is always legal BCD under these limits.
- Priority per rising edge: rst > load > tick. No action when none is active.
- rst: Y <= 0, term <= 0. at_zero = 1 and at_max = 0 in the following cycle. Reset mid-count discards the count immediately.
- load: each digit of load_val above its limit is clamped to that limit (e.g. load of 7A:6F gives 59:59). Y <= clamped value. term <= 0. A tick in the same cycle is ignored.
- Up step (mode=0, tick=1): digit 0 increments. A digit at its limit goes to 0 and carries into the next digit. The carry ripples through all digits in the same cycle, so latency is 1 cycle.
- Down step (mode=1, tick=1): digit 0 decrements. A digit at 0 goes to its limit and borrows from the next digit, rippling through all digits in the same cycle.
- Up from max:
  - WRAP=1: Y becomes 0.
  - WRAP=0: Y holds at max.
- Down from zero:
  - WRAP=1: Y becomes max.
  - WRAP=0: Y holds at 0.
- term is registered and high for exactly the one cycle after the qualifying edge. A qualifying edge is a tick step that:
  - moves Y to 0 while counting down (e.g. 00:01 -> 00:00), or
  - moves Y to max while counting up, or
  - wraps Y (up max->0 or down 0->max).
- A saturated hold (WRAP=0) produces no term, so the alarm fires once.
- at_zero and at_max are combinational decodes of the Y register and are valid in the same cycle as Y.
- A mode change takes effect on the next tick and needs no idle cycle.
- tick held high for N cycles gives N steps.

Optional Feature:
- Macro: BCD_TICK_SYNC_EN.
- Defined:
  - tick is treated as an asynchronous level, e.g. a button or the legacy trigger line.
  - It passes through a 2-flop synchronizer and a rising-edge detector. The internal step pulse is the detector output, one step per tick rising edge regardless of high duration.
  - Adds 3 cycles from tick rise to Y change.
  - rst clears the synchronizer flops.
- Not defined:
  - tick is used directly as a synchronous enable; 1-cycle latency.

Test Plan:
- Reset then up: rst=1 one cycle, mode=0, 61 single-cycle ticks -> Y=16'h0101, at_zero=0, term never pulses.
- Down to zero: load 16'h0002, mode=1, 2 ticks -> Y=16'h0000, term high exactly one cycle after 2nd tick, at_zero=1.
- Wrap versus saturate:
  - WRAP=1, Y=0, mode=1, 1 tick -> Y=16'h5959, term pulses, at_max=1.
  - WRAP=0, same stimulus -> Y stays 16'h0000, no term.
- Clamped load and priority: load_val=16'h7A6F with tick=1 same cycle -> Y=16'h5959, no step applied. Then rst and load together -> Y=0.
- Multi-group carry: NUM_GROUPS=3, load 24'h095959, mode=0, 1 tick -> Y=24'h100000.
- With BCD_TICK_SYNC_EN: tick held high 10 cycles -> exactly one step, Y changes 3 cycles after tick rise.

Source files
------------

// File: rtl/bcd_time_counter_if.sv
// Groups the tick/load/count signals of the BCD time counter into one bundle.
// The master drives the controls; the slave (the counter) drives count and flags.
interface bcd_time_counter_if #(
    parameter int W = 16
);
    logic         tick;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] Y;
    logic         at_zero;
    logic         at_max;
    logic         term;

    modport master (
        output tick, mode, load, load_val,
        input  Y, at_zero, at_max, term
    );

    modport slave (
        input  tick, mode, load, load_val,
        output Y, at_zero, at_max, term
    );
endinterface

// File: rtl/bcd_time_counter.sv
// Up/down counter of NUM_GROUPS base-60 BCD digit pairs with clamped load, wrap/saturate and term pulse.
// Latency: 1 cycle from tick to Y; 3 cycles from tick rise with BCD_TICK_SYNC_EN defined (async tick synchronised).
// Backpressure: none; every step and load is accepted, priority rst > load > tick.
module bcd_time_counter #(
    parameter int NUM_GROUPS = 2,
    parameter bit WRAP       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bcd_time_counter_if.slave bus
);
    localparam int W  = 8 * NUM_GROUPS;
    localparam int ND = 2 * NUM_GROUPS;

    // Odd digits are tens of a base-60 pair, so they stop at 5.
    function automatic logic [3:0] digit_lim(input int i);
        return (i % 2 == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] max_count();
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < ND; i++) begin
            m[4*i +: 4] = digit_lim(i);
        end
        return m;
    endfunction

    localparam logic [W-1:0] MAX_VAL = max_count();

    logic         step;
    logic [W-1:0] y_q;
    logic [W-1:0] y_d;
    logic         term_q;
    logic         term_d;
    logic [W-1:0] clamped;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_carry;
    logic         dec_borrow;
    logic [3:0]   lim;
    logic [3:0]   ld_dig;
    logic [3:0]   cur_dig;

`ifdef BCD_TICK_SYNC_EN
    logic tick_meta;
    logic tick_sync;
    logic tick_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_meta <= 1'b0;
            tick_sync <= 1'b0;
            tick_prev <= 1'b0;
        end else begin
            tick_meta <= bus.tick;
            tick_sync <= tick_meta;
            tick_prev <= tick_sync;
        end
    end

    assign step = tick_sync & ~tick_prev;
`else
    assign step = bus.tick;
`endif

    // Clamp, increment and decrement all computed in one ripple pass over the digits.
    always_comb begin
        clamped    = '0;
        inc_val    = '0;
        dec_val    = '0;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        lim        = 4'd0;
        ld_dig     = 4'd0;
        cur_dig    = 4'd0;
        for (int i = 0; i < ND; i++) begin
            lim     = digit_lim(i);
            ld_dig  = bus.load_val[4*i +: 4];
            cur_dig = y_q[4*i +: 4];

            clamped[4*i +: 4] = (ld_dig > lim) ? lim : ld_dig;

            if (!inc_carry) begin
                inc_val[4*i +: 4] = cur_dig;
            end else if (cur_dig == lim) begin
                inc_val[4*i +: 4] = 4'd0;
            end else begin
                inc_val[4*i +: 4] = cur_dig + 4'd1;
                inc_carry         = 1'b0;
            end

            if (!dec_borrow) begin
                dec_val[4*i +: 4] = cur_dig;
            end else if (cur_dig == 4'd0) begin
                dec_val[4*i +: 4] = lim;
            end else begin
                dec_val[4*i +: 4] = cur_dig - 4'd1;
                dec_borrow        = 1'b0;
            end
        end
    end

    // A carry/borrow out of the top digit means we stepped past an end of the range.
    always_comb begin
        y_d    = y_q;
        term_d = 1'b0;
        if (bus.load) begin
            y_d = clamped;
        end else if (step) begin
            if (!bus.mode) begin
                if (inc_carry) begin
                    if (WRAP) begin
                        y_d    = '0;
                        term_d = 1'b1;
                    end
                end else begin
                    y_d    = inc_val;
                    term_d = (inc_val == MAX_VAL);
                end
            end else begin
                if (dec_borrow) begin
                    if (WRAP) begin
                        y_d    = MAX_VAL;
                        term_d = 1'b1;
                    end
                end else begin
                    y_d    = dec_val;
                    term_d = (dec_val == '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= '0;
            term_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            term_q <= term_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.at_zero = (y_q == '0);
    assign bus.at_max  = (y_q == MAX_VAL);
    assign bus.term    = term_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Drives a wrapping MM:SS, a saturating MM:SS and a wrapping HH:MM:SS counter with one stimulus
// and checks each against a seconds-count model converted back to BCD.
module tb_bcd_time_counter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_time_counter_if #(.W(16)) bus_w ();
    bcd_time_counter_if #(.W(16)) bus_s ();
    bcd_time_counter_if #(.W(24)) bus_3 ();

    bcd_time_counter #(.NUM_GROUPS(2), .WRAP(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));
    bcd_time_counter #(.NUM_GROUPS(2), .WRAP(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    bcd_time_counter #(.NUM_GROUPS(3), .WRAP(1'b1)) dut_3 (.clk(clk), .rst(rst), .bus(bus_3));

    int total = 0;
    int bad   = 0;

    int   ng[3] = '{2, 2, 3};
    logic wr[3] = '{1'b1, 1'b0, 1'b1};
    int   cnt[3];
    logic term_m[3];
    logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    logic        tick_i, mode_i, load_i;
    logic [23:0] lv_i;

    function automatic int pow60(input int g);
        int p = 1;
        for (int i = 0; i < g; i++) p = p * 60;
        return p;
    endfunction

    function automatic int from_load(input logic [23:0] v, input int n);
        int c = 0;
        int u, t;
        for (int g = 0; g < n; g++) begin
            u = int'(v[8*g +: 4]);
            t = int'(v[8*g+4 +: 4]);
            if (u > 9) u = 9;
            if (t > 5) t = 5;
            c = c + (t * 10 + u) * pow60(g);
        end
        return c;
    endfunction

    function automatic logic [23:0] to_bcd(input int c, input int n);
        logic [23:0] b = '0;
        int v;
        for (int g = 0; g < n; g++) begin
            v = (c / pow60(g)) % 60;
            b[8*g +: 4]   = 4'(v % 10);
            b[8*g+4 +: 4] = 4'(v / 10);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic m, input logic l, input logic [23:0] v);
        rst = r; tick_i = t; mode_i = m; load_i = l; lv_i = v;
        bus_w.tick = t; bus_w.mode = m; bus_w.load = l; bus_w.load_val = v[15:0];
        bus_s.tick = t; bus_s.mode = m; bus_s.load = l; bus_s.load_val = v[15:0];
        bus_3.tick = t; bus_3.mode = m; bus_3.load = l; bus_3.load_val = v;
    endtask

    task automatic model_edge();
        logic stp;
        int   top;
`ifdef BCD_TICK_SYNC_EN
        stp = h2 & ~h3;
        if (rst) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = tick_i;
        end
`else
        stp = tick_i;
`endif
        for (int k = 0; k < 3; k++) begin
            top       = pow60(ng[k]) - 1;
            term_m[k] = 1'b0;
            if (rst) begin
                cnt[k] = 0;
            end else if (load_i) begin
                cnt[k] = from_load(lv_i, ng[k]);
            end else if (stp) begin
                if (!mode_i) begin
                    if (cnt[k] == top) begin
                        if (wr[k]) begin cnt[k] = 0; term_m[k] = 1'b1; end
                    end else begin
                        cnt[k]++;
                        term_m[k] = (cnt[k] == top);
                    end
                end else begin
                    if (cnt[k] == 0) begin
                        if (wr[k]) begin cnt[k] = top; term_m[k] = 1'b1; end
                    end else begin
                        cnt[k]--;
                        term_m[k] = (cnt[k] == 0);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("wrap2_y",    32'(bus_w.Y),       32'(to_bcd(cnt[0], 2)));
        chk("wrap2_zero", 32'(bus_w.at_zero), 32'(cnt[0] == 0));
        chk("wrap2_max",  32'(bus_w.at_max),  32'(cnt[0] == pow60(2) - 1));
        chk("wrap2_term", 32'(bus_w.term),    32'(term_m[0]));
        chk("sat2_y",     32'(bus_s.Y),       32'(to_bcd(cnt[1], 2)));
        chk("sat2_zero",  32'(bus_s.at_zero), 32'(cnt[1] == 0));
        chk("sat2_max",   32'(bus_s.at_max),  32'(cnt[1] == pow60(2) - 1));
        chk("sat2_term",  32'(bus_s.term),    32'(term_m[1]));
        chk("wrap3_y",    32'(bus_3.Y),       32'(to_bcd(cnt[2], 3)));
        chk("wrap3_zero", 32'(bus_3.at_zero), 32'(cnt[2] == 0));
        chk("wrap3_max",  32'(bus_3.at_max),  32'(cnt[2] == pow60(3) - 1));
        chk("wrap3_term", 32'(bus_3.term),    32'(term_m[2]));
    endtask

    task automatic cyc(input logic r, input logic t, input logic m, input logic l, input logic [23:0] v);
        drive(r, t, m, l, v);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] v;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("reset_y",    32'(bus_w.Y),       32'h0);
        chk("reset_zero", 32'(bus_w.at_zero), 32'h1);
        chk("reset_max",  32'(bus_w.at_max),  32'h0);

`ifndef BCD_TICK_SYNC_EN
        for (int i = 0; i < 61; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("up61_y",    32'(bus_w.Y),       32'h0101);
        chk("up61_zero", 32'(bus_w.at_zero), 32'h0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h000002);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
        chk("down1_term", 32'(bus_w.term), 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
        chk("down_y",    32'(bus_w.Y),       32'h0);
        chk("down_term", 32'(bus_w.term),    32'h1);
        chk("down_zero", 32'(bus_w.at_zero), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        chk("down_term_off", 32'(bus_w.term), 32'h0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
        chk("wrap_y",    32'(bus_w.Y),      32'h5959);
        chk("wrap_term", 32'(bus_w.term),   32'h1);
        chk("wrap_max",  32'(bus_w.at_max), 32'h1);
        chk("sat_y",     32'(bus_s.Y),      32'h0);
        chk("sat_term",  32'(bus_s.term),   32'h0);

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h007A6F);
        chk("clamp_y",  32'(bus_w.Y), 32'h5959);
        chk("clamp3_y", 32'(bus_3.Y), 32'h005959);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h001234);
        chk("rst_over_load", 32'(bus_w.Y), 32'h0);

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h095959);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("carry3_y", 32'(bus_3.Y), 32'h100000);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
            if (i == 2) chk("sync_not_yet", 32'(bus_w.Y), 32'h0);
            if (i == 3) chk("sync_step",    32'(bus_w.Y), 32'h1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("sync_one_step", 32'(bus_w.Y), 32'h1);
`endif

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(3))
                0:       v = 24'h595959;
                1:       v = 24'h000001;
                2:       v = 24'h595958;
                default: v = 24'($urandom);
            endcase
            cyc(($urandom_range(63) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(15) == 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
